// File: rtl/prescaler_bank.sv
// prescaler_bank
//   Multi-channel programmable tick generator. Each of NCH channels emits a
//   single-cycle tick every (period+1) mclk cycles (PERIODIC) or once per
//   start trigger (ONESHOT). Period and mode of every channel are runtime
//   writable through a single-cycle config port. Out of reset, every channel
//   is PERIODIC with period DEFAULT_PERIOD (1 Hz from 50 MHz by default).
//
// Ports
//   mclk        clock, rising edge
//   reset       asynchronous reset, active-low
//   en          global count enable; low holds all counters and blocks ticks
//   cfg_we      config write strobe (one cycle per write)
//   cfg_ch      target channel of the write; indices >= NCH are ignored
//   cfg_mode    00 OFF, 01 PERIODIC, 10 ONESHOT, 11 reserved (acts as OFF)
//   cfg_period  new period P
//   start       per-channel one-shot trigger, sampled each cycle
//   tick        registered single-cycle pulse per channel
//   busy        per-channel one-shot countdown in progress
module prescaler_bank #(
  parameter int          NCH            = 4,
  parameter int          WIDTH          = 26,
  parameter int unsigned DEFAULT_PERIOD = 49_999_999,
  parameter int          CHW            = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [NCH-1:0]   start,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy
);

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(DEFAULT_PERIOD);

  logic [WIDTH-1:0] cnt_q    [NCH];
  logic [WIDTH-1:0] cnt_d    [NCH];
  logic [WIDTH-1:0] period_q [NCH];
  logic [WIDTH-1:0] period_d [NCH];
  mode_e            mode_q   [NCH];
  mode_e            mode_d   [NCH];
  logic [NCH-1:0]   busy_q, busy_d;
  logic [NCH-1:0]   tick_q, tick_d;

  // Zero-extended channel index; an index >= NCH matches no channel in the
  // loop below, so such a write has no effect anywhere.
  logic [31:0] cfg_idx;
  assign cfg_idx = 32'(cfg_ch);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]    = cnt_q[i];
      period_d[i] = period_q[i];
      mode_d[i]   = mode_q[i];
      busy_d[i]   = busy_q[i];
      tick_d[i]   = 1'b0;

      if (cfg_we && (cfg_idx == 32'(i))) begin
        // A config write wins over start and count; a coincident start is dropped.
        period_d[i] = cfg_period;
        mode_d[i]   = mode_e'(cfg_mode);
        cnt_d[i]    = '0;
        busy_d[i]   = 1'b0;
      end else begin
        case (mode_q[i])
          MODE_PERIODIC: begin
            busy_d[i] = 1'b0;
            if (en) begin
              // Compare before increment so P = 2^WIDTH-1 never wraps early.
              if (cnt_q[i] == period_q[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + WIDTH'(1);
              end
            end
          end
          MODE_ONESHOT: begin
            if (start[i]) begin
              // Honoured even with en low; also restarts a running countdown.
              busy_d[i] = 1'b1;
              cnt_d[i]  = '0;
            end else if (busy_q[i]) begin
              if (en) begin
                if (cnt_q[i] == period_q[i]) begin
                  cnt_d[i]  = '0;
                  busy_d[i] = 1'b0;
                  tick_d[i] = 1'b1;
                end else begin
                  cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
              end
            end else begin
              cnt_d[i] = '0;
            end
          end
          default: begin
            // OFF and the reserved encoding
            cnt_d[i]  = '0;
            busy_d[i] = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]    <= '0;
        period_q[i] <= RST_PERIOD;
        mode_q[i]   <= MODE_PERIODIC;
      end
      busy_q <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        period_q[i] <= period_d[i];
        mode_q[i]   <= mode_d[i];
      end
      busy_q <= busy_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_prescaler_bank.sv
// Testbench for prescaler_bank: six channels (so that indices >= NCH can be
// driven), 8-bit counters, reset period 9 (10-cycle cadence).
module tb_prescaler_bank;

  localparam int NCH = 6;
  localparam int WIDTH = 8;
  localparam int DEFP = 9;
  localparam int CHW = 3;

  logic             mclk = 1'b0;
  logic             reset;
  logic             en;
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [1:0]       cfg_mode;
  logic [WIDTH-1:0] cfg_period;
  logic [NCH-1:0]   start;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   busy;

  prescaler_bank #(
    .NCH(NCH), .WIDTH(WIDTH), .DEFAULT_PERIOD(DEFP)
  ) dut (
    .mclk(mclk), .reset(reset), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .start(start),
    .tick(tick), .busy(busy)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;
  } exp_t;

  exp_t sb[$];

  int vecs = 0;
  int fails = 0;
  int n = 0;               // rising edges since the last reset release
  int refn [NCH];          // edge at which a periodic channel's count was 0
  int per  [NCH];          // period of a periodic channel
  logic [NCH-1:0] os_mask; // channels whose expectation is given explicitly

  // Push the expectation for the coming edge, then take that edge.
  // Periodic channels: tick after edge n iff n > refn and (n-refn) is a
  // multiple of per+1; an edge with en low ticks nothing and delays the phase.
  task automatic step(input logic [NCH-1:0] ot, input logic [NCH-1:0] ob);
    exp_t e;
    n++;
    for (int i = 0; i < NCH; i++) begin
      if (os_mask[i]) begin
        e.tick[i] = ot[i];
        e.busy[i] = ob[i];
      end else begin
        e.busy[i] = 1'b0;
        if (!en) begin
          refn[i]++;
          e.tick[i] = 1'b0;
        end else begin
          e.tick[i] = (n > refn[i]) && (((n - refn[i]) % (per[i] + 1)) == 0);
        end
      end
    end
    sb.push_back(e);
    @(posedge mclk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (3) @(posedge mclk);
    #1;
    vecs++;
    if ({tick, busy} !== '0) begin
      fails++;
      $display("FAIL reset_hold: tick/busy got %b/%b want 0/0", tick, busy);
    end
    reset = 1'b1;
    n = 0;
    os_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      refn[i] = 0;
      per[i] = DEFP;
    end
    for (int k = 0; k < 25; k++) begin
      step('0, '0);
      e = sb.pop_front();
      vecs++;
      if ({tick, busy} !== e) begin
        fails++;
        $display("FAIL reset_cadence edge %0d: tick/busy got %b/%b want %b/%b",
                 n, tick, busy, e.tick, e.busy);
      end
    end
  endtask

  task automatic test_periodic_write();
    exp_t e;
    for (int k = 0; k < 21; k++) begin
      if (k == 0) begin
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_mode = 2'b01; cfg_period = 8'd3;
        refn[2] = n + 1;
        per[2] = 3;
      end else begin
        cfg_we = 1'b0;
      end
      step('0, '0);
      e = sb.pop_front();
      vecs++;
      if ({tick, busy} !== e) begin
        fails++;
        $display("FAIL periodic_write edge %0d: tick/busy got %b/%b want %b/%b",
                 n, tick, busy, e.tick, e.busy);
      end
    end
  endtask

  // ch1 ONESHOT P=5: clean run, then a run restarted when cnt has reached 3.
  task automatic test_oneshot();
    exp_t e;
    logic [NCH-1:0] ot, ob;
    for (int k = 0; k < 32; k++) begin
      if (k == 0) begin
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_mode = 2'b10; cfg_period = 8'd5;
        os_mask[1] = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
      start = '0;
      start[1] = (k == 3) || (k == 16) || (k == 20);
      ot = '0;
      ob = '0;
      ot[1] = (k == 9) || (k == 26);
      ob[1] = (k >= 3 && k <= 8) || (k >= 16 && k <= 25);
      step(ot, ob);
      e = sb.pop_front();
      vecs++;
      if ({tick, busy} !== e) begin
        fails++;
        $display("FAIL oneshot edge %0d: tick/busy got %b/%b want %b/%b",
                 n, tick, busy, e.tick, e.busy);
      end
    end
    start = '0;
  endtask

  // ch0 PERIODIC P=0, then en low for 5 edges; ch1 one-shot started while en low.
  task automatic test_p0_en();
    exp_t e;
    logic [NCH-1:0] ot, ob;
    for (int k = 0; k < 30; k++) begin
      if (k == 0) begin
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_mode = 2'b01; cfg_period = 8'd0;
        refn[0] = n + 1;
        per[0] = 0;
      end else begin
        cfg_we = 1'b0;
      end
      en = !(k >= 5 && k <= 9);
      start = '0;
      start[1] = (k == 5);
      ot = '0;
      ob = '0;
      ot[1] = (k == 15);
      ob[1] = (k >= 5 && k <= 14);
      step(ot, ob);
      e = sb.pop_front();
      vecs++;
      if ({tick, busy} !== e) begin
        fails++;
        $display("FAIL p0_en edge %0d: tick/busy got %b/%b want %b/%b",
                 n, tick, busy, e.tick, e.busy);
      end
    end
    en = 1'b1;
    start = '0;
  endtask

  // Writes to nonexistent channels, then a write to ch3 colliding with start[3].
  task automatic test_cfg_guard();
    exp_t e;
    for (int k = 0; k < 11; k++) begin
      cfg_we = 1'b0;
      start = '0;
      if (k == 0) begin
        cfg_we = 1'b1; cfg_ch = 3'd6; cfg_mode = 2'b00; cfg_period = 8'd0;
      end else if (k == 1) begin
        cfg_we = 1'b1; cfg_ch = 3'd7; cfg_mode = 2'b10; cfg_period = 8'd1;
      end else if (k == 4) begin
        cfg_we = 1'b1; cfg_ch = 3'd3; cfg_mode = 2'b10; cfg_period = 8'd2;
        start[3] = 1'b1;
        os_mask[3] = 1'b1;
      end
      step('0, '0);
      e = sb.pop_front();
      vecs++;
      if ({tick, busy} !== e) begin
        fails++;
        $display("FAIL cfg_guard edge %0d: tick/busy got %b/%b want %b/%b",
                 n, tick, busy, e.tick, e.busy);
      end
    end
    cfg_we = 1'b0;
    start = '0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [NCH-1:0] ob;
    for (int k = 0; k < 3; k++) begin
      start = '0;
      start[1] = (k == 0);
      ob = '0;
      ob[1] = 1'b1;
      step('0, ob);
      e = sb.pop_front();
      vecs++;
      if ({tick, busy} !== e) begin
        fails++;
        $display("FAIL pre_reset edge %0d: tick/busy got %b/%b want %b/%b",
                 n, tick, busy, e.tick, e.busy);
      end
    end
    start = '0;
    // Mid-cycle assertion: outputs must clear without waiting for an edge.
    #2;
    reset = 1'b0;
    #1;
    vecs++;
    if ({tick, busy} !== '0) begin
      fails++;
      $display("FAIL async_clear: tick/busy got %b/%b want 0/0", tick, busy);
    end
    @(posedge mclk);
    #1;
    n++;
    reset = 1'b1;
    os_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      refn[i] = n;
      per[i] = DEFP;
    end
    for (int k = 0; k < 21; k++) begin
      step('0, '0);
      e = sb.pop_front();
      vecs++;
      if ({tick, busy} !== e) begin
        fails++;
        $display("FAIL post_reset edge %0d: tick/busy got %b/%b want %b/%b",
                 n, tick, busy, e.tick, e.busy);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b1;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_mode = '0;
    cfg_period = '0;
    start = '0;
    os_mask = '0;
    test_reset();
    test_periodic_write();
    test_oneshot();
    test_p0_en();
    test_cfg_guard();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
